// File: rtl/vram_access_scheduler.sv
// Arbitrates one single-port VRAM bank between the renderer, which has absolute priority, and a CPU.
// CPU writes pass through a small posted-write FIFO; CPU reads wait until that FIFO is empty.
module vram_access_scheduler #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          render_active,
    input  logic [ADDR_W-1:0]             render_addr,
    output logic [DATA_W-1:0]             render_q,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_data,
    output logic [DATA_W-1:0]             cpu_q,
    output logic                          cpu_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_d,
    output logic                          ram_we,
    input  logic [DATA_W-1:0]             ram_q
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_CAP   = 2'd2,
        ST_RD_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic                r_ack;
    logic [DATA_W-1:0]   r_cpu_q;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty    = (r_level == {LVL_W{1'b0}});
    // The ack cycle masks cpu_req so a held request is never accepted twice.
    assign w_push     = cpu_req & cpu_we & ~w_full & ~r_ack;
    assign w_pop      = ~render_active & ~w_empty & (r_state == ST_IDLE);
    assign render_q   = ram_q;
    assign cpu_q      = r_cpu_q;
    assign cpu_ack    = r_ack;
    assign fifo_level = r_level;

    // Read state machine: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req && !cpu_we && !r_ack && w_empty) begin
                    w_state_nxt = ST_RD_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                if (!render_active) begin
                    w_state_nxt = ST_RD_CAP;
                end else begin
                    w_state_nxt = ST_RD_ISSUE;
                end
            end
            ST_RD_CAP: w_state_nxt = ST_RD_ACK;
            ST_RD_ACK: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // VRAM port mux: renderer first, then FIFO drain, then read issue
    always_comb begin
        ram_addr = {ADDR_W{1'b0}};
        ram_d    = {DATA_W{1'b0}};
        ram_we   = 1'b0;
        if (render_active) begin
            ram_addr = render_addr;
        end else if (w_pop) begin
            ram_addr = r_mem_addr[r_rd_ptr];
            ram_d    = r_mem_data[r_rd_ptr];
            ram_we   = 1'b1;
        end else if (r_state == ST_RD_ISSUE) begin
            ram_addr = cpu_addr;
        end else begin
            ram_addr = {ADDR_W{1'b0}};
        end
    end

    // State, FIFO bookkeeping, ack and read-data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
            r_ack    <= 1'b0;
            r_cpu_q  <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_push | (r_state == ST_RD_CAP);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // ram_q already holds the CPU word latched at the issue edge.
            if (r_state == ST_RD_CAP) begin
                r_cpu_q <= ram_q;
            end
        end
    end

    // FIFO storage; entries are only read after being written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= cpu_addr;
            r_mem_data[r_wr_ptr] <= cpu_data;
        end
    end
endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a behavioural 1-cycle-latency VRAM bank.
module tb_vram_access_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        render_active = 1'b0;
    logic [13:0] render_addr = 14'h0;
    logic [31:0] render_q;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = 14'h0;
    logic [31:0] cpu_data = 32'h0;
    logic [31:0] cpu_q;
    logic        cpu_ack;
    logic [2:0]  fifo_level;
    logic [13:0] ram_addr;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q = 32'h0;

    logic [31:0] mem [0:16383];
    logic [13:0] log_a [$];
    logic [31:0] log_d [$];
    int          viol = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    vram_access_scheduler #(.ADDR_W(14), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .render_active(render_active), .render_addr(render_addr),
        .render_q(render_q), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_q(cpu_q), .cpu_ack(cpu_ack), .fifo_level(fifo_level),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port synchronous VRAM model
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    // Commit log and renderer-priority monitor
    always @(negedge clk) begin
        if (!reset && ram_we) begin
            log_a.push_back(ram_addr);
            log_d.push_back(ram_d);
        end
        if (render_active && (ram_we || ram_addr != render_addr)) viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int bound, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < bound);
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [31:0] d, output int lat);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
        wait_ack(50, lat);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic check_log(input string tag, input int idx, input logic [13:0] a, input logic [31:0] d);
        logic [13:0] oa;
        logic [31:0] od;
        oa = (idx < log_a.size()) ? log_a[idx] : 14'h3fff;
        od = (idx < log_d.size()) ? log_d[idx] : 32'hffff_ffff;
        check({tag, "_addr"}, 64'(oa), 64'(a));
        check({tag, "_data"}, 64'(od), 64'(d));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ram_we"}, 64'(ram_we), 64'd0);
        check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_ram_d"}, 64'(ram_d), 64'd0);
        check({tag, "_ack"}, 64'(cpu_ack), 64'd0);
        check({tag, "_cpu_q"}, 64'(cpu_q), 64'd0);
        check({tag, "_level"}, 64'(fifo_level), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int acks;
        logic [13:0] ea;
        logic [31:0] ed;

        // Reset state
        tick(); tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // Idle writes: ack after 1 cycle, three commits in order
        log_a.delete(); log_d.delete();
        for (int i = 0; i < 3; i++) begin
            ed = 32'hA0 + 32'(i) * 32'h10;
            cpu_write(14'h10 + 14'(i), ed, lat);
            check("idle_wr_lat", 64'(lat), 64'd1);
        end
        repeat (4) tick();
        check("idle_commits", 64'(log_a.size()), 64'd3);
        for (int i = 0; i < 3; i++) check_log("idle_log", i, 14'h10 + 14'(i), 32'hA0 + 32'(i) * 32'h10);
        check("idle_level", 64'(fifo_level), 64'd0);

        // Renderer priority: 4 buffered, 5th stalls, all 6 commit in order afterwards
        log_a.delete(); log_d.delete();
        render_active = 1'b1; render_addr = 14'h0123;
        for (int i = 0; i < 4; i++) begin
            cpu_write(14'h20 + 14'(i), 32'h100 + 32'(i), lat);
            check("prio_wr_lat", 64'(lat), 64'd1);
        end
        check("prio_level_full", 64'(fifo_level), 64'd4);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h24; cpu_data = 32'h104;
        acks = 0;
        repeat (10) begin tick(); if (cpu_ack) acks++; end
        check("prio_stall_ack", 64'(acks), 64'd0);
        check("prio_stall_level", 64'(fifo_level), 64'd4);
        repeat (80) tick();
        check("prio_no_commit", 64'(log_a.size()), 64'd0);
        render_active = 1'b0;
        wait_ack(20, lat);
        check("prio_5th_acked", 64'(cpu_ack), 64'd1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        cpu_write(14'h25, 32'h105, lat);
        check("prio_6th_lat", 64'(lat), 64'd1);
        repeat (8) tick();
        check("prio_commits", 64'(log_a.size()), 64'd6);
        for (int i = 0; i < 6; i++) check_log("prio_log", i, 14'h20 + 14'(i), 32'h100 + 32'(i));
        check("prio_viol", 64'(viol), 64'd0);
        check("prio_level_end", 64'(fifo_level), 64'd0);

        // Read-after-write held back by the renderer until the FIFO drains
        render_active = 1'b1; render_addr = 14'h0456;
        cpu_write(14'h0200, 32'h1234_5678, lat);
        check("raw_wr_lat", 64'(lat), 64'd1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
        acks = 0;
        repeat (5) begin tick(); if (cpu_ack) acks++; end
        check("raw_held_ack", 64'(acks), 64'd0);
        check("raw_held_level", 64'(fifo_level), 64'd1);
        render_active = 1'b0;
        // One drain cycle empties the FIFO, then issue/capture/ack take three more.
        wait_ack(20, lat);
        check("raw_rd_lat", 64'(lat), 64'd4);
        check("raw_cpu_q", 64'(cpu_q), 64'h1234_5678);
        cpu_req = 1'b0;
        tick();

        // Read interrupted by the renderer in the capture cycle
        cpu_write(14'h0300, 32'hDEAD_BEEF, lat);
        cpu_write(14'h0055, 32'h55AA_55AA, lat);
        repeat (4) tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0300;
        tick();
        check("int_issue_ack", 64'(cpu_ack), 64'd0);
        tick();
        render_active = 1'b1; render_addr = 14'h0055;
        tick();
        check("int_ack", 64'(cpu_ack), 64'd1);
        check("int_cpu_q", 64'(cpu_q), 64'hDEAD_BEEF);
        check("int_render_q", 64'(render_q), 64'h55AA_55AA);
        cpu_req = 1'b0;
        tick();
        render_active = 1'b0;
        tick();

        // Simultaneous push and pop, then ordering across pointer wrap
        log_a.delete(); log_d.delete();
        render_active = 1'b1;
        cpu_write(14'h40, 32'h1000, lat);
        cpu_write(14'h41, 32'h1001, lat);
        check("pp_level_pre", 64'(fifo_level), 64'd2);
        render_active = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h42; cpu_data = 32'h1002;
        tick();
        check("pp_ack", 64'(cpu_ack), 64'd1);
        check("pp_level_same", 64'(fifo_level), 64'd2);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        for (int i = 3; i < 13; i++) begin
            cpu_write(14'h40 + 14'(i), 32'h1000 + 32'(i), lat);
            check("wrap_wr_lat", 64'(lat), 64'd1);
        end
        repeat (6) tick();
        check("wrap_commits", 64'(log_a.size()), 64'd13);
        for (int i = 0; i < 13; i++) check_log("wrap_log", i, 14'h40 + 14'(i), 32'h1000 + 32'(i));

        // Async reset with three buffered writes
        render_active = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(14'h60 + 14'(i), 32'h2000 + 32'(i), lat);
        check("rst_level_pre", 64'(fifo_level), 64'd3);
        log_a.delete(); log_d.delete();
        #2;
        reset = 1'b1; render_active = 1'b0;
        #1;
        check_zero_outputs("rst_fifo");
        #1;
        reset = 1'b0;
        acks = 0;
        repeat (6) begin tick(); if (cpu_ack) acks++; end
        check("rst_fifo_ack", 64'(acks), 64'd0);
        check("rst_fifo_commits", 64'(log_a.size()), 64'd0);

        // Async reset with a read in the capture cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0300;
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_rd");
        cpu_req = 1'b0;
        #1;
        reset = 1'b0;
        acks = 0;
        repeat (6) begin tick(); if (cpu_ack) acks++; end
        check("rst_rd_ack", 64'(acks), 64'd0);
        check("rst_rd_commits", 64'(log_a.size()), 64'd0);
        cpu_write(14'h0077, 32'hCAFE_F00D, lat);
        check("post_rst_wr_lat", 64'(lat), 64'd1);
        repeat (3) tick();
        check("post_rst_commits", 64'(log_a.size()), 64'd1);
        check_log("post_rst_log", 0, 14'h0077, 32'hCAFE_F00D);
        ea = 14'h0077;
        check("post_rst_mem", 64'(mem[ea]), 64'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
